// File: rtl/cdc_gray_pkg.sv
// Gray-code pointer helpers shared by both halves of the Gray-pointer FIFO crossing.
package cdc_gray_pkg;

    localparam int unsigned MaxPtrW = 32;

    function automatic int unsigned ptr_width(input int unsigned log_depth);
        return log_depth + 1;
    endfunction

    function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs convert correctly because leading zeros leave the XOR prefix unchanged.
    function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] g);
        logic [MaxPtrW-1:0] b;
        b[MaxPtrW-1] = g[MaxPtrW-1];
        for (int i = MaxPtrW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_gray_dst_lane.sv
// One destination-side lane of a Gray-pointer FIFO crossing: pointer sync, read pointer, head, fill.
// Optional registered output stage when CDC_GRAY_DST_SPILL_EN is defined.
module cdc_gray_dst_lane
    import cdc_gray_pkg::*;
#(
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned DataWidth  = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [(2**LogDepth)-1:0][DataWidth-1:0] async_data_i,
    input  logic [LogDepth:0]                       async_wptr_i,
    output logic [LogDepth:0]                       async_rptr_o,
    output logic [DataWidth-1:0]                    data_o,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    input  logic                                    flush_i,
    output logic [LogDepth:0]                       fill_o
);

    localparam int unsigned PtrW = ptr_width(LogDepth);

    logic [SyncStages-1:0][PtrW-1:0] sync_q, sync_d;
    logic [PtrW-1:0]                 wsync;
    logic [PtrW-1:0]                 rptr_q, rptr_d;
    logic [PtrW-1:0]                 rgray_q, rgray_d;
    logic                            fifo_valid;
    logic [DataWidth-1:0]            fifo_data;
    logic                            fifo_pop;

    // sync_q[0] captures the asynchronous pointer; the last stage is the only one decoded.
    assign sync_d = {sync_q[SyncStages-2:0], async_wptr_i};
    assign wsync  = PtrW'(gray2bin(MaxPtrW'(sync_q[SyncStages-1])));

    assign fifo_valid = (wsync != rptr_q);
    assign fifo_data  = async_data_i[rptr_q[LogDepth-1:0]];
    assign fill_o     = wsync - rptr_q;

    always_comb begin
        rptr_d = rptr_q;
        if (flush_i) begin
            rptr_d = wsync;
        end else if (fifo_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
    end

    assign rgray_d      = PtrW'(bin2gray(MaxPtrW'(rptr_d)));
    assign async_rptr_o = rgray_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            rptr_q  <= '0;
            rgray_q <= '0;
        end else begin
            sync_q  <= sync_d;
            rptr_q  <= rptr_d;
            rgray_q <= rgray_d;
        end
    end

`ifdef CDC_GRAY_DST_SPILL_EN
    logic                 spill_vld_q, spill_vld_d;
    logic [DataWidth-1:0] spill_data_q, spill_data_d;

    // The stage refills in the same cycle it is drained, so back-to-back pops keep full rate.
    assign fifo_pop = fifo_valid && (!spill_vld_q || ready_i) && !flush_i;

    always_comb begin
        spill_vld_d  = spill_vld_q;
        spill_data_d = spill_data_q;
        if (flush_i) begin
            spill_vld_d = 1'b0;
        end else if (fifo_pop) begin
            spill_vld_d  = 1'b1;
            spill_data_d = fifo_data;
        end else if (ready_i) begin
            spill_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            spill_vld_q  <= 1'b0;
            spill_data_q <= '0;
        end else begin
            spill_vld_q  <= spill_vld_d;
            spill_data_q <= spill_data_d;
        end
    end

    assign valid_o = spill_vld_q;
    assign data_o  = spill_data_q;
`else
    assign fifo_pop = fifo_valid && ready_i;
    assign valid_o  = fifo_valid;
    assign data_o   = fifo_data;
`endif

endmodule

// File: rtl/cdc_gray_dst_array.sv
// Array of independent destination-side Gray-pointer FIFO lanes sharing one clock and reset.
// Optional registered output stage per lane: define CDC_GRAY_DST_SPILL_EN.
module cdc_gray_dst_array
    import cdc_gray_pkg::*;
#(
    parameter int unsigned NumChan    = 5,
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned DataWidth  = 32
) (
    input  logic                                                 dst_clk_i,
    input  logic                                                 dst_rst_ni,
    input  logic [NumChan-1:0][(2**LogDepth)-1:0][DataWidth-1:0] async_data_i,
    input  logic [NumChan-1:0][LogDepth:0]                       async_wptr_i,
    output logic [NumChan-1:0][LogDepth:0]                       async_rptr_o,
    output logic [NumChan-1:0][DataWidth-1:0]                    dst_data_o,
    output logic [NumChan-1:0]                                   dst_valid_o,
    input  logic [NumChan-1:0]                                   dst_ready_i,
    input  logic [NumChan-1:0]                                   dst_flush_i,
    output logic [NumChan-1:0][LogDepth:0]                       dst_fill_o
);

    if (LogDepth < 1) begin : g_bad_logdepth
        $error("cdc_gray_dst_array: LogDepth must be at least 1");
    end
    if (SyncStages < 2) begin : g_bad_syncstages
        $error("cdc_gray_dst_array: SyncStages must be at least 2");
    end
    if (NumChan < 1) begin : g_bad_numchan
        $error("cdc_gray_dst_array: NumChan must be at least 1");
    end

    for (genvar c = 0; c < NumChan; c++) begin : g_lane
        cdc_gray_dst_lane #(
            .LogDepth   (LogDepth),
            .SyncStages (SyncStages),
            .DataWidth  (DataWidth)
        ) u_lane (
            .clk_i        (dst_clk_i),
            .rst_ni       (dst_rst_ni),
            .async_data_i (async_data_i[c]),
            .async_wptr_i (async_wptr_i[c]),
            .async_rptr_o (async_rptr_o[c]),
            .data_o       (dst_data_o[c]),
            .valid_o      (dst_valid_o[c]),
            .ready_i      (dst_ready_i[c]),
            .flush_i      (dst_flush_i[c]),
            .fill_o       (dst_fill_o[c])
        );
    end

endmodule

// File: tb/tb_cdc_gray_dst_array.sv
// Directed bench for cdc_gray_dst_array at NumChan=5, LogDepth=1, SyncStages=2 (default build).
module tb_cdc_gray_dst_array;

    localparam int NC = 5;
    localparam int LD = 1;
    localparam int SS = 2;
    localparam int DW = 32;

    logic                              clk;
    logic                              rst_n;
    logic [NC-1:0][(2**LD)-1:0][DW-1:0] async_data;
    logic [NC-1:0][LD:0]               async_wptr;
    logic [NC-1:0][LD:0]               async_rptr;
    logic [NC-1:0][DW-1:0]             dst_data;
    logic [NC-1:0]                     dst_valid;
    logic [NC-1:0]                     dst_ready;
    logic [NC-1:0]                     dst_flush;
    logic [NC-1:0][LD:0]               dst_fill;

    int total;
    int bad;

    cdc_gray_dst_array #(
        .NumChan    (NC),
        .LogDepth   (LD),
        .SyncStages (SS),
        .DataWidth  (DW)
    ) dut (
        .dst_clk_i    (clk),
        .dst_rst_ni   (rst_n),
        .async_data_i (async_data),
        .async_wptr_i (async_wptr),
        .async_rptr_o (async_rptr),
        .dst_data_o   (dst_data),
        .dst_valid_o  (dst_valid),
        .dst_ready_i  (dst_ready),
        .dst_flush_i  (dst_flush),
        .dst_fill_o   (dst_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] gray2(input logic [1:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [1:0] wb;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        async_data = '0;
        async_wptr = '0;
        dst_ready  = '0;
        dst_flush  = '0;

        // Reset held for three cycles
        tick(); tick(); tick();
        for (int c = 0; c < NC; c++) begin
            check($sformatf("rst_valid%0d", c), 64'(dst_valid[c]), 64'd0);
            check($sformatf("rst_fill%0d", c), 64'(dst_fill[c]), 64'd0);
            check($sformatf("rst_rptr%0d", c), 64'(async_rptr[c]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Lane 0: single entry, two-edge latency, one pop
        async_data[0][0] = 32'hA5;
        async_wptr[0]    = 2'b01;
        tick();
        check("l0_valid_edge1", 64'(dst_valid[0]), 64'd0);
        tick();
        check("l0_valid_edge2", 64'(dst_valid[0]), 64'd1);
        check("l0_data", 64'(dst_data[0]), 64'hA5);
        check("l0_fill", 64'(dst_fill[0]), 64'd1);
        dst_ready[0] = 1'b1;
        tick();
        dst_ready[0] = 1'b0;
        check("l0_rptr_after_pop", 64'(async_rptr[0]), 64'h1);
        check("l0_valid_after_pop", 64'(dst_valid[0]), 64'd0);
        check("l0_fill_after_pop", 64'(dst_fill[0]), 64'd0);

        // Lane 1: full FIFO drained with ready held
        async_data[1][0] = 32'h11;
        async_data[1][1] = 32'h22;
        async_wptr[1]    = 2'b11;
        tick(); tick();
        check("l1_fill_full", 64'(dst_fill[1]), 64'd2);
        check("l1_data0", 64'(dst_data[1]), 64'h11);
        dst_ready[1] = 1'b1;
        tick();
        check("l1_valid1", 64'(dst_valid[1]), 64'd1);
        check("l1_data1", 64'(dst_data[1]), 64'h22);
        check("l1_fill1", 64'(dst_fill[1]), 64'd1);
        tick();
        dst_ready[1] = 1'b0;
        check("l1_valid_empty", 64'(dst_valid[1]), 64'd0);
        check("l1_rptr", 64'(async_rptr[1]), 64'h3);

        // Lane 2: six push/pop pairs across the pointer wrap
        wb = 2'd0;
        for (int k = 0; k < 6; k++) begin
            async_data[2][wb[0]] = 32'h100 + k;
            wb = wb + 2'd1;
            async_wptr[2] = gray2(wb);
            tick(); tick();
            check($sformatf("l2_valid%0d", k), 64'(dst_valid[2]), 64'd1);
            check($sformatf("l2_data%0d", k), 64'(dst_data[2]), 64'(32'h100 + k));
            check($sformatf("l2_fill%0d", k), 64'(dst_fill[2]), 64'd1);
            dst_ready[2] = 1'b1;
            tick();
            dst_ready[2] = 1'b0;
            check($sformatf("l2_empty%0d", k), 64'(dst_valid[2]), 64'd0);
            check($sformatf("l2_rptr%0d", k), 64'(async_rptr[2]), 64'(gray2(wb)));
        end

        // Lane 3: flush and ready together on a full lane
        async_data[3][0] = 32'h33;
        async_data[3][1] = 32'h44;
        async_wptr[3]    = 2'b11;
        tick(); tick();
        check("l3_fill_pre", 64'(dst_fill[3]), 64'd2);
        dst_flush[3] = 1'b1;
        dst_ready[3] = 1'b1;
        tick();
        dst_flush[3] = 1'b0;
        dst_ready[3] = 1'b0;
        check("l3_fill_post", 64'(dst_fill[3]), 64'd0);
        check("l3_valid_post", 64'(dst_valid[3]), 64'd0);
        check("l3_rptr_post", 64'(async_rptr[3]), 64'h3);
        tick();
        check("l3_rptr_hold", 64'(async_rptr[3]), 64'h3);

        // Lane 0 stalled full while lane 4 streams
        async_data[0][1] = 32'hB1;
        async_data[0][0] = 32'hB2;
        async_wptr[0]    = 2'b10;
        wb = 2'd0;
        for (int k = 0; k < 4; k++) begin
            async_data[4][wb[0]] = 32'h400 + k;
            wb = wb + 2'd1;
            async_wptr[4] = gray2(wb);
            tick(); tick();
            check($sformatf("l4_data%0d", k), 64'(dst_data[4]), 64'(32'h400 + k));
            check($sformatf("l4_fill%0d", k), 64'(dst_fill[4]), 64'd1);
            dst_ready[4] = 1'b1;
            tick();
            dst_ready[4] = 1'b0;
            check($sformatf("l4_empty%0d", k), 64'(dst_valid[4]), 64'd0);
        end
        check("l0_stall_fill", 64'(dst_fill[0]), 64'd2);
        check("l0_stall_valid", 64'(dst_valid[0]), 64'd1);
        check("l0_stall_data", 64'(dst_data[0]), 64'hB1);
        check("l0_stall_rptr", 64'(async_rptr[0]), 64'h1);
        dst_ready[0] = 1'b1;
        tick();
        check("l0_drain_data", 64'(dst_data[0]), 64'hB2);
        tick();
        dst_ready[0] = 1'b0;
        check("l0_drain_rptr", 64'(async_rptr[0]), 64'h2);
        check("l0_drain_valid", 64'(dst_valid[0]), 64'd0);

        // Reset arriving with a pop pending aborts it
        async_data[0][1] = 32'hC3;
        async_wptr[0]    = 2'b00;
        tick(); tick();
        check("l0_pre_reset_valid", 64'(dst_valid[0]), 64'd1);
        dst_ready[0] = 1'b1;
        rst_n        = 1'b0;
        tick();
        dst_ready[0] = 1'b0;
        check("mid_rst_rptr", 64'(async_rptr[0]), 64'd0);
        check("mid_rst_valid", 64'(dst_valid), 64'd0);
        check("mid_rst_fill", 64'(dst_fill), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
